card_selector: RTL and testbench

CARD_SELECTOR -- requirements
Module: card_selector

---
 rtl/card_selector.sv | 156 +++++++++++++++
 tb/tb_card_selector.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/card_selector.sv
// Memory-game card selector: debounced-edge cursor navigation, two-card selection FSM, pair compare.
// Optional build macro SKIP_MATCHED_EN: cursor moves skip over already-paired slots (busy during search).
module card_selector (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_next,
  input  logic        btn_prev,
  input  logic        btn_sel,
  input  logic [47:0] card_ids,
  input  logic        clear,
  input  logic        new_game,
  output logic [1:0]  cartas_seleccionadas,
  output logic [3:0]  card_a,
  output logic [3:0]  card_b,
  output logic [3:0]  cursor,
  output logic        m,
  output logic        pareja,
  output logic        match_valid,
  output logic [15:0] matched_mask,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ONE, TWO, RESULT} state_t;

  state_t     state;
  logic [2:0] sync_n, sync_p, sync_s;
  logic       e_n, e_p, e_s;
  logic       sel_e, mv_fwd, mv_bwd, all_matched, sel_ok;
  logic       busy_q;
  logic [2:0] ids [16];

  for (genvar k = 0; k < 16; k++) begin : g_id
    assign ids[k] = card_ids[3*k +: 3];
  end

  // [0],[1] synchronize; [2] is the delayed copy for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_n <= '0;
      sync_p <= '0;
      sync_s <= '0;
    end else begin
      sync_n <= {sync_n[1:0], btn_next};
      sync_p <= {sync_p[1:0], btn_prev};
      sync_s <= {sync_s[1:0], btn_sel};
    end
  end

  assign e_n = sync_n[1] & ~sync_n[2];
  assign e_p = sync_p[1] & ~sync_p[2];
  assign e_s = sync_s[1] & ~sync_s[2];

  // sel beats a coincident move; next+prev together cancel
  assign sel_e       = e_s & ~busy_q;
  assign mv_fwd      = e_n & ~e_p & ~e_s & ~busy_q;
  assign mv_bwd      = e_p & ~e_n & ~e_s & ~busy_q;
  assign all_matched = &matched_mask;
  assign sel_ok      = sel_e & ~matched_mask[cursor] &
                       ((state == IDLE) | ((state == ONE) & (cursor != card_a)));

`ifdef SKIP_MATCHED_EN
  logic       dir_q;
  logic       step_fwd;
  logic [3:0] step;

  assign step_fwd = busy_q ? dir_q : mv_fwd;
  assign step     = step_fwd ? cursor + 4'd1 : cursor - 4'd1;

  // keep stepping while the slot just landed on is already paired
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cursor <= '0;
      busy_q <= 1'b0;
      dir_q  <= 1'b0;
    end else if (new_game) begin
      cursor <= '0;
      busy_q <= 1'b0;
      dir_q  <= 1'b0;
    end else if (busy_q) begin
      cursor <= step;
      busy_q <= matched_mask[step];
    end else if ((mv_fwd | mv_bwd) & ~all_matched) begin
      cursor <= step;
      busy_q <= matched_mask[step];
      dir_q  <= mv_fwd;
    end
  end
`else
  assign busy_q = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cursor <= '0;
    else if (new_game)
      cursor <= '0;
    else if (mv_fwd & ~all_matched)
      cursor <= cursor + 4'd1;
    else if (mv_bwd & ~all_matched)
      cursor <= cursor - 4'd1;
  end
`endif

  assign busy = busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                <= IDLE;
      cartas_seleccionadas <= '0;
      card_a               <= '0;
      card_b               <= '0;
      m                    <= 1'b0;
      pareja               <= 1'b0;
      match_valid          <= 1'b0;
      matched_mask         <= '0;
    end else begin
      m           <= 1'b0;
      match_valid <= 1'b0;
      if (new_game) begin
        state                <= IDLE;
        cartas_seleccionadas <= '0;
        pareja               <= 1'b0;
        matched_mask         <= '0;
      end else if (clear) begin
        state                <= IDLE;
        cartas_seleccionadas <= '0;
        pareja               <= 1'b0;
      end else begin
        case (state)
          IDLE: if (sel_ok) begin
            card_a               <= cursor;
            cartas_seleccionadas <= 2'd1;
            m                    <= 1'b1;
            state                <= ONE;
          end
          ONE: if (sel_ok) begin
            card_b               <= cursor;
            cartas_seleccionadas <= 2'd2;
            m                    <= 1'b1;
            state                <= TWO;
          end
          TWO: begin
            pareja      <= (ids[card_a] == ids[card_b]);
            match_valid <= 1'b1;
            if (ids[card_a] == ids[card_b]) begin
              matched_mask[card_a] <= 1'b1;
              matched_mask[card_b] <= 1'b1;
            end
            state <= RESULT;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_card_selector.sv
// Directed bench for card_selector: vector table for the turn flow plus hand sequences for reset/new_game/skip search.
module tb_card_selector;
  logic        clk = 1'b0;
  logic        rst;
  logic        btn_next, btn_prev, btn_sel;
  logic [47:0] card_ids;
  logic        clear, new_game;
  logic [1:0]  cartas_seleccionadas;
  logic [3:0]  card_a, card_b, cursor;
  logic        m, pareja, match_valid;
  logic [15:0] matched_mask;
  logic        busy;

  card_selector dut (
    .clk(clk), .rst(rst), .btn_next(btn_next), .btn_prev(btn_prev), .btn_sel(btn_sel),
    .card_ids(card_ids), .clear(clear), .new_game(new_game),
    .cartas_seleccionadas(cartas_seleccionadas), .card_a(card_a), .card_b(card_b),
    .cursor(cursor), .m(m), .pareja(pareja), .match_valid(match_valid),
    .matched_mask(matched_mask), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic n, p, s, c;
    logic [3:0] cur;
    logic m;
    logic [1:0] cnt;
    logic [3:0] a, b;
    logic mv, par;
    logic [15:0] mask;
  } vec_t;

  vec_t tbl [20];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(input logic n, p, s, c, input logic [3:0] cur, input logic mm,
                              input logic [1:0] cnt, input logic [3:0] a, b,
                              input logic mv, par, input logic [15:0] mask);
    mk = '{n:n, p:p, s:s, c:c, cur:cur, m:mm, cnt:cnt, a:a, b:b, mv:mv, par:par, mask:mask};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // raw pulse one cycle; returns at the negedge following the action edge
  task automatic press(input logic n, input logic p, input logic s);
    @(negedge clk); btn_next = n; btn_prev = p; btn_sel = s;
    @(negedge clk); btn_next = 0; btn_prev = 0; btn_sel = 0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic apply(input vec_t v, input int i);
    @(negedge clk); btn_next = v.n; btn_prev = v.p; btn_sel = v.s;
    @(negedge clk); btn_next = 0; btn_prev = 0; btn_sel = 0;
    @(negedge clk); clear = v.c;
    chk($sformatf("r%0d m_early", i), 32'(m), 32'd0);
    @(negedge clk); clear = 0;
    chk($sformatf("r%0d cursor", i), 32'(cursor), 32'(v.cur));
    chk($sformatf("r%0d m", i), 32'(m), 32'(v.m));
    chk($sformatf("r%0d count", i), 32'(cartas_seleccionadas), 32'(v.cnt));
    chk($sformatf("r%0d card_a", i), 32'(card_a), 32'(v.a));
    chk($sformatf("r%0d card_b", i), 32'(card_b), 32'(v.b));
    chk($sformatf("r%0d busy", i), 32'(busy), 32'd0);
    @(negedge clk);
    chk($sformatf("r%0d match_valid", i), 32'(match_valid), 32'(v.mv));
    chk($sformatf("r%0d pareja", i), 32'(pareja), 32'(v.par));
    chk($sformatf("r%0d mask", i), 32'(matched_mask), 32'(v.mask));
  endtask

  initial begin
    logic pulse_seen;
    //           n  p  s  c  cur m cnt a  b  mv par mask
    tbl[0]  = mk(0, 1, 0, 0, 15, 0, 0, 0, 0, 0, 0, 16'h0000);
    tbl[1]  = mk(1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 16'h0000);
    tbl[2]  = mk(1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 16'h0000);
    tbl[3]  = mk(0, 0, 1, 0,  0, 1, 1, 0, 0, 0, 0, 16'h0000);
    tbl[4]  = mk(1, 0, 0, 0,  1, 0, 1, 0, 0, 0, 0, 16'h0000);
    tbl[5]  = mk(0, 0, 1, 0,  1, 1, 2, 0, 1, 1, 1, 16'h0003);
    tbl[6]  = mk(0, 0, 1, 0,  1, 0, 2, 0, 1, 0, 1, 16'h0003);
    tbl[7]  = mk(0, 0, 0, 1,  1, 0, 0, 0, 1, 0, 0, 16'h0003);
    tbl[8]  = mk(1, 0, 0, 0,  2, 0, 0, 0, 1, 0, 0, 16'h0003);
    tbl[9]  = mk(0, 0, 1, 0,  2, 1, 1, 2, 1, 0, 0, 16'h0003);
    tbl[10] = mk(1, 0, 0, 0,  3, 0, 1, 2, 1, 0, 0, 16'h0003);
    tbl[11] = mk(0, 0, 1, 0,  3, 1, 2, 2, 3, 1, 0, 16'h0003);
    tbl[12] = mk(0, 0, 0, 1,  3, 0, 0, 2, 3, 0, 0, 16'h0003);
    tbl[13] = mk(1, 0, 0, 0,  4, 0, 0, 2, 3, 0, 0, 16'h0003);
    tbl[14] = mk(1, 0, 0, 0,  5, 0, 0, 2, 3, 0, 0, 16'h0003);
    tbl[15] = mk(0, 0, 1, 0,  5, 1, 1, 5, 3, 0, 0, 16'h0003);
    tbl[16] = mk(0, 0, 1, 0,  5, 0, 1, 5, 3, 0, 0, 16'h0003);
    tbl[17] = mk(1, 0, 0, 0,  6, 0, 1, 5, 3, 0, 0, 16'h0003);
    tbl[18] = mk(0, 0, 1, 1,  6, 0, 0, 5, 3, 0, 0, 16'h0003);
    tbl[19] = mk(1, 0, 1, 0,  6, 1, 1, 6, 3, 0, 0, 16'h0003);

    rst = 1; btn_next = 0; btn_prev = 0; btn_sel = 0; clear = 0; new_game = 0;
    card_ids = '0;
    card_ids[2:0] = 3'd3; card_ids[5:3] = 3'd3; card_ids[8:6] = 3'd4; card_ids[11:9] = 3'd5;
    repeat (3) @(negedge clk);
    chk("rst cursor", 32'(cursor), 32'd0);
    chk("rst count", 32'(cartas_seleccionadas), 32'd0);
    chk("rst outs", 32'({m, pareja, match_valid, busy}), 32'd0);
    chk("rst mask", 32'(matched_mask), 32'd0);
    rst = 0;
    @(negedge clk);

    for (int i = 0; i < 20; i++) apply(tbl[i], i);

`ifndef SKIP_MATCHED_EN
    // matched slot 1 is reachable but must not be selectable
    for (int i = 0; i < 5; i++) press(0, 1, 0);
    chk("matched reach cursor", 32'(cursor), 32'd1);
    press(0, 0, 1);
    chk("matched sel m", 32'(m), 32'd0);
    chk("matched sel count", 32'(cartas_seleccionadas), 32'd1);
`endif

    // reset mid-turn (state ONE)
    @(negedge clk); rst = 1;
    #1;
    chk("midrst cursor", 32'(cursor), 32'd0);
    chk("midrst count", 32'(cartas_seleccionadas), 32'd0);
    chk("midrst cards", 32'({card_a, card_b}), 32'd0);
    chk("midrst outs", 32'({m, pareja, match_valid, busy}), 32'd0);
    chk("midrst mask", 32'(matched_mask), 32'd0);
    @(negedge clk); rst = 0;
    pulse_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (m || match_valid) pulse_seen = 1;
    end
    chk("postrst no pulse", 32'(pulse_seen), 32'd0);

    // rebuild a match, then new_game clears board and cursor
    press(0, 0, 1); press(1, 0, 0); press(0, 0, 1);
    @(negedge clk);
    chk("ng pre mask", 32'(matched_mask), 32'h0003);
    press(1, 0, 0);
    chk("ng pre cursor", 32'(cursor), 32'd2);
    new_game = 1;
    @(negedge clk); new_game = 0;
    chk("ng cursor", 32'(cursor), 32'd0);
    chk("ng mask", 32'(matched_mask), 32'd0);
    chk("ng count", 32'(cartas_seleccionadas), 32'd0);

`ifdef SKIP_MATCHED_EN
    // pair slots 1/2 and 3/4 so the mask becomes 0x001E
    card_ids = '0;
    card_ids[2:0] = 3'd5; card_ids[5:3] = 3'd1; card_ids[8:6] = 3'd1;
    card_ids[11:9] = 3'd2; card_ids[14:12] = 3'd2;
    press(1, 0, 0); press(0, 0, 1); press(1, 0, 0); press(0, 0, 1);
    @(negedge clk); clear = 1; @(negedge clk); clear = 0;
    press(1, 0, 0); press(0, 0, 1); press(1, 0, 0); press(0, 0, 1);
    @(negedge clk); clear = 1; @(negedge clk); clear = 0;
    chk("skip mask", 32'(matched_mask), 32'h001E);
    chk("skip cursor4", 32'(cursor), 32'd4);
    press(0, 1, 0);
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    chk("skip settle busy", 32'(busy), 32'd0);
    chk("skip back cursor", 32'(cursor), 32'd0);
    @(negedge clk); btn_next = 1;
    @(negedge clk); btn_next = 0;
    @(negedge clk);
    @(negedge clk);
    chk("skip c1", 32'({busy, cursor}), 32'h11);
    btn_next = 1;
    @(negedge clk); btn_next = 0;
    chk("skip c2", 32'({busy, cursor}), 32'h12);
    @(negedge clk);
    chk("skip c3", 32'({busy, cursor}), 32'h13);
    @(negedge clk);
    chk("skip c4", 32'({busy, cursor}), 32'h14);
    @(negedge clk);
    chk("skip c5", 32'({busy, cursor}), 32'h05);
    repeat (3) @(negedge clk);
    chk("skip edge dropped", 32'({busy, cursor}), 32'h05);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
